id_ex_pipe_reg: RTL

//  ID/EX pipeline register, directly downstream of the control-signal bubble mux.

---
 rtl/id_ex_pipe_reg.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall (hold) and flush (bubble) control.
// Optional bubble counter enabled by defining IDEX_BUBBLE_CNT_EN.
module id_ex_pipe_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FUNCT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [1:0]            ALUop_in,
  input  logic                  ALUSrc_in,
  input  logic                  branch_in,
  input  logic                  jump_in,
  input  logic                  memRead_in,
  input  logic                  memWrite_in,
  input  logic                  memToReg_in,
  input  logic                  regWrite_in,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [XLEN-1:0]       rs1_data_in,
  input  logic [XLEN-1:0]       rs2_data_in,
  input  logic [XLEN-1:0]       imm_in,
  input  logic [REG_ADDR_W-1:0] rs1_in,
  input  logic [REG_ADDR_W-1:0] rs2_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [FUNCT_W-1:0]    funct_in,
  output logic                  valid_out,
  output logic [1:0]            ALUop_out,
  output logic                  ALUSrc_out,
  output logic                  branch_out,
  output logic                  jump_out,
  output logic                  memRead_out,
  output logic                  memWrite_out,
  output logic                  memToReg_out,
  output logic                  regWrite_out,
  output logic [XLEN-1:0]       pc_out,
  output logic [XLEN-1:0]       rs1_data_out,
  output logic [XLEN-1:0]       rs2_data_out,
  output logic [XLEN-1:0]       imm_out,
  output logic [REG_ADDR_W-1:0] rs1_out,
  output logic [REG_ADDR_W-1:0] rs2_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [FUNCT_W-1:0]    funct_out,
  output logic [31:0]           bubble_cnt
);

  localparam int CTRL_W = 9;

  logic                  valid_q, valid_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [CTRL_W-1:0]     ctrl_in_s;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]       imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [FUNCT_W-1:0]    funct_q, funct_d;

  assign ctrl_in_s = {ALUop_in, ALUSrc_in, branch_in, jump_in,
                      memRead_in, memWrite_in, memToReg_in, regWrite_in};

  // Next-state selection: flush beats stall beats load.
  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    funct_d    = funct_q;
    if (flush) begin
      valid_d    = 1'b0;
      ctrl_d     = '0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      funct_d    = '0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d    = valid_in;
      // An invalid slot must never carry side-effecting controls into EX.
      ctrl_d     = valid_in ? ctrl_in_s : {CTRL_W{1'b0}};
      pc_d       = pc_in;
      rs1_data_d = rs1_data_in;
      rs2_data_d = rs2_data_in;
      imm_d      = imm_in;
      rs1_d      = rs1_in;
      rs2_d      = rs2_in;
      rd_d       = rd_in;
      funct_d    = funct_in;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct_q    <= funct_d;
    end
  end

  assign valid_out    = valid_q;
  assign {ALUop_out, ALUSrc_out, branch_out, jump_out,
          memRead_out, memWrite_out, memToReg_out, regWrite_out} = ctrl_q;
  assign pc_out       = pc_q;
  assign rs1_data_out = rs1_data_q;
  assign rs2_data_out = rs2_data_q;
  assign imm_out      = imm_q;
  assign rs1_out      = rs1_q;
  assign rs2_out      = rs2_q;
  assign rd_out       = rd_q;
  assign funct_out    = funct_q;

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_s;

  assign bubble_s = flush | (~stall & ~valid_in);

  // Saturating bubble count.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_s && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= 32'h0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = 32'h0;
`endif

endmodule
